// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

   // Arbiter control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // Oversample ticks per UART bit
   localparam int OVERSAMPLE  = 16;

   // Default frame: start + 8 data + stop; any WAIT timeout must exceed this
   localparam int FRAME_BITS  = 10;
   localparam int FRAME_TICKS = FRAME_BITS * OVERSAMPLE;

endpackage

// File: rtl/uart_rr_select.sv
// Round-robin pick: first valid requester at or after rr_ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module uart_rr_select
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   sel_idx,
   output logic               any_vld
);

   localparam logic [PTR_W:0] N_W = (PTR_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl_vld;
   logic [2*NUM_REQ-1:0] shifted;
   logic [NUM_REQ-1:0]   rot_vld;
   logic [PTR_W-1:0]     offs;
   logic                 found;
   logic [PTR_W:0]       sum;
   logic [PTR_W:0]       wrapped;

   // Rotate so that rr_ptr lands at bit 0; doubling the vector gives wrap-around
   assign dbl_vld = {req_valid, req_valid};
   assign shifted = dbl_vld >> rr_ptr;
   assign rot_vld = shifted[NUM_REQ-1:0];

   // Lowest set bit of the rotated vector is the distance from rr_ptr
   always_comb begin
      offs  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot_vld[i]) begin
            offs  = PTR_W'(i);
            found = 1'b1;
         end
      end
   end

   // Rotate the distance back to an absolute index, modulo NUM_REQ
   assign sum     = {1'b0, rr_ptr} + {1'b0, offs};
   assign wrapped = sum - N_W;
   assign sel_idx = (sum >= N_W) ? wrapped[PTR_W-1:0] : sum[PTR_W-1:0];
   assign any_vld = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; optional WAIT timeout via UART_TX_ARB_TIMEOUT_EN.
// Latency: req_valid seen in IDLE at edge N -> tx_valid/req_ready pulse in cycle N+1; one IDLE cycle between frames.
// Backpressure: grant held until tx_done (or timeout); requests outside IDLE are not looked at.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int DATA_LENGTH   = 8,
   parameter int TIMEOUT_TICKS = 256
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           tx_valid,
   output logic [DATA_LENGTH-1:0]         tx_data,
   input  logic                           tx_done,
   input  logic                           baud_timer,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           busy,
   output logic                           timeout_err
);

   localparam int                 PTR_W   = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0]   LAST_ID = PTR_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

   arb_state_t       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] sel_idx;
   logic             any_vld;
   logic [PTR_W-1:0] ptr_after_grant;

   uart_rr_select #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_sel (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .sel_idx   (sel_idx),
      .any_vld   (any_vld)
   );

   // Search for the next frame starts just past whoever was served last
   assign ptr_after_grant = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int             CNT_W     = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);

   logic [CNT_W-1:0] tmo_cnt;
`else
   // The transmitter tick and limit only matter when the watchdog is built
   logic unused_baud;
   assign unused_baud = baud_timer;
   localparam int unused_timeout_ticks = TIMEOUT_TICKS;
`endif

   // Arbiter FSM; every output is a register updated alongside the state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
         req_ready   <= '0;
         grant_id    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         // Pulses last exactly one cycle unless re-asserted below
         tx_valid    <= 1'b0;
         req_ready   <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (any_vld) begin
                  state     <= ISSUE;
                  tx_data   <= req_data[sel_idx*DATA_LENGTH +: DATA_LENGTH];
                  grant_id  <= sel_idx;
                  tx_valid  <= 1'b1;
                  req_ready <= ONE_HOT << sel_idx;
                  busy      <= 1'b1;
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT: begin
               // A completion on the limit tick is still a clean completion
               if (tx_done) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= ptr_after_grant;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (baud_timer) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TMO_LAST) begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     rr_ptr      <= ptr_after_grant;
                     timeout_err <= 1'b1;
                  end
               end
`endif
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboarded grants plus directed timing checks.
// Latency: checks ISSUE one cycle after IDLE sees a request, one IDLE cycle between frames.
// Backpressure: modelled requesters hold their byte until the cycle after req_ready.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DL        = 8;
   localparam int TMO       = 256;
   localparam int FRAME_CYC = 4;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*DL-1:0]   req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    tx_valid;
   logic [DL-1:0]           tx_data;
   logic                    tx_done;
   logic                    baud_timer;
   logic [1:0]              grant_id;
   logic                    busy;
   logic                    timeout_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .DATA_LENGTH   (DL),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .baud_timer  (baud_timer),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] dat;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] src_mem [NUM_REQ][8];
   int         src_rd  [NUM_REQ];
   int         src_wr  [NUM_REQ];
   logic [NUM_REQ-1:0] pop_pend;
   logic       auto_done;
   bit         baud_en;
   int         txm_cnt;
   int         cyc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   task automatic load(input int i, input logic [7:0] d);
      src_mem[i][src_wr[i] % 8] = d;
      src_wr[i]++;
   endtask

   task automatic expect_grant(input int i, input logic [7:0] d);
      exp_t e;
      e.id  = 2'(i);
      e.dat = d;
      exp_q.push_back(e);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (src_rd[i] != src_wr[i]);
         req_data[i*DL +: DL] = req_valid[i] ? src_mem[i][src_rd[i] % 8] : 8'h00;
      end
   endtask

   // One clock: requesters, transmitter model and baud tick all update #1 after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      tx_done = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pop_pend[i]) src_rd[i]++;
      pop_pend = req_ready;
      drive_reqs();
      if (tx_valid) txm_cnt = FRAME_CYC;
      else if (txm_cnt > 0) begin
         txm_cnt--;
         if (txm_cnt == 0 && auto_done) tx_done = 1'b1;
      end
      baud_timer = baud_en ? ~baud_timer : 1'b0;
   endtask

   task automatic chk_zero(input string pfx);
      check_eq({pfx, "_tx_valid"},    tx_valid,    0);
      check_eq({pfx, "_tx_data"},     tx_data,     0);
      check_eq({pfx, "_req_ready"},   req_ready,   0);
      check_eq({pfx, "_grant_id"},    grant_id,    0);
      check_eq({pfx, "_busy"},        busy,        0);
      check_eq({pfx, "_timeout_err"}, timeout_err, 0);
   endtask

   // Run until every expected grant has been seen and the arbiter is idle again
   task automatic drain(input string tag, input bit chk_gap);
      int n = 0;
      int last = -1;
      logic prev_busy = busy;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         tick();
         n++;
         if (chk_gap && tx_valid) begin
            check_eq({tag, "_idle_before_issue"}, prev_busy, 0);
            if (last >= 0) check_eq({tag, "_frame_gap"}, cyc - last, FRAME_CYC + 2);
            last = cyc;
         end
         prev_busy = busy;
      end
      check_eq({tag, "_drained"}, exp_q.size(), 0);
      check_eq({tag, "_idle"}, busy, 0);
   endtask

   // Scoreboard: every tx_valid pulse must match the next expected grant
   always @(negedge clk) begin
      if (reset_n && tx_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_frame", {30'b0, grant_id}, 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("sb_grant_id",  grant_id,  mon_e.id);
            check_eq("sb_tx_data",   tx_data,   mon_e.dat);
            check_eq("sb_req_ready", req_ready, 4'b0001 << mon_e.id);
         end
      end else if (reset_n && req_ready != '0) begin
         check_eq("ready_without_valid", req_ready, 0);
      end
   end

   initial begin
      req_valid  = '0;
      req_data   = '0;
      tx_done    = 1'b0;
      baud_timer = 1'b0;
      auto_done  = 1'b0;
      baud_en    = 1'b0;
      txm_cnt    = 0;
      cyc        = 0;
      pop_pend   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src_rd[i] = 0;
         src_wr[i] = 0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      reset_n = 1'b1;
      tick();

      // Round robin: all four valid with two bytes each
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NUM_REQ; i++) begin
            load(i, 8'(8'h10 * (k + 1) + i));
            expect_grant(i, 8'(8'h10 * (k + 1) + i));
         end
      auto_done = 1'b1;
      drive_reqs();
      drain("rr", 1'b1);

      // Single request from requester 2, manual completion
      auto_done = 1'b0;
      load(2, 8'hA5);
      expect_grant(2, 8'hA5);
      drive_reqs();
      tick();
      check_eq("single_tx_valid",  tx_valid,  1);
      check_eq("single_req_ready", req_ready, 4'b0100);
      check_eq("single_tx_data",   tx_data,   8'hA5);
      check_eq("single_grant_id",  grant_id,  2);
      check_eq("single_busy",      busy,      1);
      tick();
      check_eq("wait_tx_valid",  tx_valid,  0);
      check_eq("wait_req_ready", req_ready, 0);
      check_eq("wait_tx_data",   tx_data,   8'hA5);
      check_eq("wait_busy",      busy,      1);
      tick();
      tick();
      check_eq("wait_hold_busy", busy, 1);

      // tx_done and a new request together: IDLE first, ISSUE next
      load(1, 8'h3C);
      expect_grant(1, 8'h3C);
      drive_reqs();
      tx_done = 1'b1;
      tick();
      check_eq("done_wins_busy",     busy,     0);
      check_eq("done_wins_tx_valid", tx_valid, 0);
      check_eq("done_wins_grant",    grant_id, 2);
      tick();
      check_eq("after_done_tx_valid", tx_valid, 1);
      check_eq("after_done_grant",    grant_id, 1);
      tick();
      tx_done = 1'b1;
      tick();
      check_eq("frame2_end_busy", busy, 0);

      // Stray tx_done in IDLE changes nothing
      tx_done = 1'b1;
      tick();
      check_eq("stray_busy",     busy,     0);
      check_eq("stray_tx_valid", tx_valid, 0);
      check_eq("stray_grant",    grant_id, 1);

      // Pointer at 2, only requesters 0 and 1 valid
      load(0, 8'h50);
      load(1, 8'h51);
      expect_grant(0, 8'h50);
      expect_grant(1, 8'h51);
      auto_done = 1'b1;
      drive_reqs();
      drain("skip", 1'b0);

      // Reset in WAIT clears everything immediately
      auto_done = 1'b0;
      load(3, 8'h77);
      expect_grant(3, 8'h77);
      drive_reqs();
      tick();
      check_eq("pre_reset_grant", grant_id, 3);
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("mid_reset");
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      check_eq("post_reset_tx_valid",  tx_valid,  0);
      check_eq("post_reset_req_ready", req_ready, 0);
      check_eq("post_reset_busy",      busy,      0);
      load(3, 8'h77);
      load(1, 8'h71);
      expect_grant(1, 8'h71);
      expect_grant(3, 8'h77);
      auto_done = 1'b1;
      drive_reqs();
      drain("post_reset", 1'b0);

`ifdef UART_TX_ARB_TIMEOUT_EN
      begin
         int  n;
         int  ticks;
         bit  seen;
         bit  err_seen;
         logic bt;
         auto_done = 1'b0;
         baud_en   = 1'b1;
         load(0, 8'h90);
         load(1, 8'h91);
         expect_grant(0, 8'h90);
         expect_grant(1, 8'h91);
         drive_reqs();
         n = 0;
         while (!tx_valid && n < 10) begin tick(); n++; end
         check_eq("tmo_issue", tx_valid, 1);
         tick();
         ticks = 0; seen = 0; n = 0;
         while (!seen && n < 2000) begin
            bt = baud_timer;
            tick();
            n++;
            if (bt) ticks++;
            if (timeout_err) seen = 1;
         end
         check_eq("tmo_err_seen", seen, 1);
         check_eq("tmo_tick_cnt", ticks, TMO);
         check_eq("tmo_idle",     busy, 0);
         n = 0;
         while (!tx_valid && n < 10) begin tick(); n++; end
         check_eq("tmo_next_grant", grant_id, 1);
         tick();
         ticks = 0; n = 0;
         while (ticks < 160 && n < 2000) begin
            bt = baud_timer;
            tick();
            n++;
            if (bt) ticks++;
         end
         tx_done  = 1'b1;
         err_seen = 0;
         repeat (600) begin
            tick();
            if (timeout_err) err_seen = 1;
         end
         check_eq("tmo_clean_done_no_err", err_seen, 0);
         check_eq("tmo_clean_done_idle",   busy, 0);
         baud_en = 1'b0;
      end
`else
      baud_en = 1'b1;
      repeat (20) tick();
      check_eq("timeout_err_tied", timeout_err, 0);
      baud_en = 1'b0;
`endif

      check_eq("sb_empty_at_end", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte sources. It accepts a byte from one requester and issues it to the transmitter as a single-cycle `tx_valid` pulse. It then holds the grant until the transmitter reports frame completion. It sits between the command/status sources and the transmitter, and is the only driver of the transmitter's `tx_valid`/`tx_data`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2
- `DATA_LENGTH`, 8: byte width; must match the transmitter
- `TIMEOUT_TICKS`, 256: `baud_timer` ticks allowed in WAIT before abort (used only with `UART_TX_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester byte available
- `req_data`  in  NUM_REQ*DATA_LENGTH  requester i's byte in bits [i*DATA_LENGTH +: DATA_LENGTH]
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse
- `tx_valid`  out  1  start-of-frame pulse to the transmitter
- `tx_data`  out  DATA_LENGTH  byte to the transmitter, registered
- `tx_done`  in  1  one-cycle pulse from the transmitter at the end of the stop bit
- `baud_timer`  in  1  16x oversample tick, shared with the transmitter
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester
- `busy`  out  1  high in ISSUE and WAIT
- `timeout_err`  out  1  one-cycle pulse when a WAIT is aborted

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any `req_valid` is high, select the first requester at or after `rr_ptr`, searching upward with wrap-around.
  - At the clock edge, capture that requester's byte into `tx_data`, set `grant_id`, and go to ISSUE.
  - If no `req_valid` is high, stay in IDLE.
- **ISSUE** (exactly one cycle):
  - `tx_valid` = 1 and `req_ready[grant_id]` = 1.
  - Go to WAIT.
- **WAIT:**
  - `tx_valid` = 0; `tx_data` and `grant_id` are held.
  - On `tx_done`, go to IDLE and set `rr_ptr` = (`grant_id`+1) mod `NUM_REQ`.
- **Requester rule:** hold `req_valid` and data stable until `req_ready`. A requester may deassert or present its next byte in the cycle after `req_ready`.
- **Ignored inputs:** `req_valid` changes outside IDLE; `tx_done` outside WAIT.
- **Fairness:** a requester waits at most `NUM_REQ`-1 frames.
- **Reset values:**
  - Outputs: `tx_valid`=0, `tx_data`=0, `req_ready`=0, `grant_id`=0, `busy`=0, `timeout_err`=0.
  - Internal: state IDLE, `rr_ptr`=0, timeout counter 0.
- **Reset mid-frame:** all state clears immediately. No pending grant is remembered and no `req_ready` is issued afterwards. The requester re-presents its byte.

## Timing
- Acceptance latency: `req_valid` seen in IDLE at edge N → `tx_valid` and `req_ready` high in cycle N+1.
- The transmitter samples `tx_valid` in its idle state, so exactly one pulse is issued per frame.
- Back-to-back frames:
  - `tx_done` at edge M → IDLE in cycle M+1 → ISSUE in cycle M+2.
  - There is exactly one IDLE cycle between frames.
- `tx_done` and a new `req_valid` in the same cycle: `tx_done` wins. The request is evaluated in the following IDLE cycle.
- `rr_ptr` wraps from `NUM_REQ`-1 to 0.
- `busy` is registered with the state: high from the ISSUE cycle through the last WAIT cycle.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments on each `baud_timer` in WAIT. Its width is $clog2(`TIMEOUT_TICKS`+1).
  - When the count reaches `TIMEOUT_TICKS` without `tx_done`, `timeout_err` pulses for one cycle, the state goes to IDLE, and `rr_ptr` advances as for a normal completion.
  - `tx_done` arriving in the same cycle as the limit counts as a normal completion; no error is raised.
- **Not defined:** WAIT lasts until `tx_done`, indefinitely. `timeout_err` is tied to 0 and no counter is built.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE/ISSUE/WAIT).
  - Oversample constant 16 (ticks per bit).
  - Default frame length constant 10 bits = 160 ticks; `TIMEOUT_TICKS` must exceed it.
- Sub-module `uart_rr_select`: combinational rotate-priority-rotate. Inputs `req_valid` and `rr_ptr`; outputs index and any-valid.
- Registers, FSM and timeout counter live in `uart_tx_arbiter`.

## Test plan
- **Single request:** requester 2 presents 0xA5 in IDLE → next cycle `tx_valid`=1, `req_ready`=4'b0100, `tx_data`=0xA5, `grant_id`=2. `busy` stays 1 until one cycle after `tx_done`.
- **Round robin:** all four requesters valid continuously, `tx_done` after each frame → grant order 0,1,2,3,0. Exactly one IDLE cycle between frames.
- **Pointer skip:** `rr_ptr`=2, only requesters 0 and 1 valid → grant 0, then 1.
- **Ignored input:** stray `tx_done` in IDLE → no state change. `tx_done` in the same cycle as a new request → IDLE first, ISSUE one cycle later.
- **Reset in WAIT:** `reset_n` low during WAIT → all outputs 0 immediately. After release, the held request is re-granted from `rr_ptr`=0.
- **Timeout** (with `UART_TX_ARB_TIMEOUT_EN`, `TIMEOUT_TICKS`=256): no `tx_done` → `timeout_err` pulses after the 256th `baud_timer` tick in WAIT, then the next requester is granted. With `tx_done` at tick 160 → no error.
